pc_control: RTL and testbench

- Parametrised program-counter unit that replaces the free-running pc+4 register in the single-cycle core.
- Adds branch, JAL and JALR redirection, stall handling, and an instruction-memory range wrap.
- Adds run/halt/single-step control from a board switch and a debounced push-button, so the core can be stepped while the 7-segment debug mux shows state.
- Produces `commit_en`, which gates the register-file and data-memory write enables.

---
 rtl/pc_control.sv | 136 +++++++++++++
 tb/tb_pc_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Program-counter unit: branch/JAL/JALR redirection, stall, IMEM wrap, and
// run/halt/single-step control from a debounced button. Optional macro: PC_RETIRE_CNT_EN.
module pc_control #(
  parameter int               XLEN            = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR    = '0,
  parameter int               IMEM_DEPTH      = 64,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_mode,
  input  logic            step_btn,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            commit_en,
  output logic [1:0]      state,
  output logic            fault,
  output logic [31:0]     retired_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  localparam logic [XLEN:0] IMEM_SPAN = (XLEN+1)'(4 * IMEM_DEPTH);
  localparam int            CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [XLEN-1:0]  pc_q, pc_d, tgt;
  state_e           state_q;
  logic             fault_q;
  logic             redirect, tgt_bad, commit;
  logic [XLEN:0]    seq_off;

  logic [1:0]       sync_q;
  logic             db_level_q, step_pulse_q;
  logic [CNT_W-1:0] db_cnt_q;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign commit    = !stall && (state_q == ST_RUN || state_q == ST_STEP);
  assign commit_en = commit;
  assign pc        = pc_q;
  assign state     = state_q;
  assign fault     = fault_q;

  // Offsets are taken relative to RESET_VECTOR so one unsigned compare covers
  // both ends of the range: targets below the base wrap to huge offsets.
  assign seq_off = {1'b0, pc_q - RESET_VECTOR} + (XLEN+1)'(4);

  // NOTE: every branch assigns every output first-hand, so no latch is inferred.
  always_comb begin
    redirect = jalr | jump | branch_taken;
    if (jalr)                       tgt = (rs1_data + imm) & ~XLEN'(1);
    else if (jump || branch_taken)  tgt = pc_q + imm;
    else if (seq_off == IMEM_SPAN)  tgt = RESET_VECTOR;
    else                            tgt = pc_plus4;
    tgt_bad = redirect && ((tgt[1:0] != 2'b00) ||
                           ({1'b0, tgt - RESET_VECTOR} >= IMEM_SPAN));
    pc_d    = (commit && !tgt_bad) ? tgt : pc_q;
  end

  // Button path: 2-FF synchroniser, stability counter, rising-edge pulse.
  // NOTE: sequential state uses non-blocking assignments only, so the later
  // default-override of step_pulse_q reads the pre-edge db_level_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= 2'b00;
      db_level_q   <= 1'b0;
      db_cnt_q     <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], step_btn};
      step_pulse_q <= 1'b0;
      if (sync_q[1] == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == CNT_MAX) begin
        db_cnt_q     <= '0;
        db_level_q   <= ~db_level_q;
        step_pulse_q <= ~db_level_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: reset is synchronous; it wins over every state including FAULT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_HALT;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_q | (commit & tgt_bad);
      unique case (state_q)
        // HALT still reacts while stall is high so a press is never lost.
        ST_HALT: begin
          if (run_mode)          state_q <= ST_RUN;
          else if (step_pulse_q) state_q <= ST_STEP;
        end
        ST_RUN: begin
          if (commit && tgt_bad)        state_q <= ST_FAULT;
          else if (!stall && !run_mode) state_q <= ST_HALT;
        end
        ST_STEP: begin
          if (commit) state_q <= tgt_bad ? ST_FAULT : ST_HALT;
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_HALT;
      endcase
    end
  end

`ifdef PC_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                             retired_q <= '0;
    else if (commit && (retired_q != '1))   retired_q <= retired_q + 32'd1;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed scenarios plus randomized
// stimulus compared each cycle against a behavioural model.
module tb_pc_control;

  localparam logic [31:0] RV    = 32'h40;
  localparam int          DEPTH = 16;
  localparam int          DEB   = 4;
  localparam int HALT = 0, RUN = 1, STEP = 2, FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n, run_mode, step_btn, stall, branch_taken, jump, jalr;
  logic [31:0] imm, rs1_data;
  logic [31:0] pc, pc_plus4, retired_count;
  logic        commit_en, fault;
  logic [1:0]  state;

  pc_control #(
    .XLEN(32), .RESET_VECTOR(RV), .IMEM_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .step_btn(step_btn),
    .stall(stall), .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .pc(pc), .pc_plus4(pc_plus4),
    .commit_en(commit_en), .state(state), .fault(fault),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] m_pc;
  int          m_state;
  bit          m_fault, m_lvl, m_pulse, m_valid;
  longint      m_ret;
  int          m_run;
  bit          m_hist[$];

  function automatic bit m_commit();
    return !stall && (m_state == RUN || m_state == STEP);
  endfunction

  function automatic logic [31:0] exp_ret();
`ifdef PC_RETIRE_CNT_EN
    return m_ret[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_edge();
    bit          c, redir, bad, synced, old_pulse;
    logic [31:0] t;
    longint      off;
    if (!rst_n) begin
      m_pc = RV; m_state = HALT; m_fault = 0; m_ret = 0;
      m_lvl = 0; m_pulse = 0; m_run = 0; m_hist = '{1'b0, 1'b0};
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    c     = m_commit();
    redir = jalr || jump || branch_taken;
    if (jalr)                      t = (rs1_data + imm) & 32'hFFFF_FFFE;
    else if (jump || branch_taken) t = m_pc + imm;
    else if (m_pc + 4 == RV + 4 * DEPTH) t = RV;
    else                           t = m_pc + 4;
    off = longint'(t) - longint'(RV);
    bad = redir && ((t % 4) != 0 || off < 0 || off >= 4 * DEPTH);

    old_pulse = m_pulse;
    case (m_state)
      HALT:    if (run_mode) m_state = RUN; else if (old_pulse) m_state = STEP;
      RUN:     if (!stall) begin
                 if (bad) m_state = FAULT; else if (!run_mode) m_state = HALT;
               end
      STEP:    if (!stall) m_state = bad ? FAULT : HALT;
      default: ;
    endcase
    if (c && !bad) m_pc = t;
    if (c && bad)  m_fault = 1;
    if (c && m_ret < 64'hFFFF_FFFF) m_ret++;

    synced = m_hist.pop_front();
    m_hist.push_back(step_btn);
    m_pulse = 0;
    if (synced != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = !m_lvl; m_run = 0; m_pulse = m_lvl;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    #3;
    if (m_valid) begin
      check("commit_en", commit_en, m_commit());
      check("pc_plus4", pc_plus4, m_pc + 4);
    end
    model_edge();
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("state", state, m_state);
      check("fault", fault, m_fault);
      check("retired_count", retired_count, exp_ret());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_redirects();
    jalr = 0; jump = 0; branch_taken = 0; imm = 0; rs1_data = 0;
  endtask

  int fault_age;

  initial begin
    m_valid = 0;
    rst_n = 0; run_mode = 1; step_btn = 0; stall = 0;
    clear_redirects();
    @(posedge clk);
    #1;

    // Free run out of reset
    ticks(2);
    rst_n = 1;
    tick();
    check("first_state_run", state, RUN);
    check("first_pc", pc, RV);
    ticks(4);
    check("free_pc", pc, RV + 32'h10);
`ifdef PC_RETIRE_CNT_EN
    check("free_retired", retired_count, 32'd4);
`endif

    // Branch back, then JALR beats a simultaneous branch
    branch_taken = 1; imm = 32'hFFFF_FFF8;
    tick();
    check("branch_pc", pc, RV + 32'h08);
    jalr = 1; rs1_data = RV + 32'h21; imm = 32'h3;
    tick();
    check("jalr_pc", pc, RV + 32'h24);

    // Misaligned jump faults and freezes
    clear_redirects();
    jump = 1; imm = 32'h6;
    tick();
    check("fault_flag", fault, 1'b1);
    check("fault_state", state, FAULT);
    check("fault_pc", pc, RV + 32'h24);
    clear_redirects();
    ticks(10);
    check("fault_hold_pc", pc, RV + 32'h24);

    // Reset out of FAULT, then single-step with a bouncing button
    rst_n = 0; tick();
    rst_n = 1; run_mode = 0;
    check("rst_fault_state", state, HALT);
    for (int i = 0; i < 3; i++) begin
      step_btn = 1; ticks(2);
      step_btn = 0; ticks(2);
    end
    check("bounce_no_step", pc, RV);
    step_btn = 1; ticks(20);
    step_btn = 0; ticks(10);
    check("step1_pc", pc, RV + 32'h4);
    check("step1_state", state, HALT);

    // Second press while stalled: STEP must wait for the stall to drop
    step_btn = 1; stall = 1;
    ticks(12);
    check("step_stalled_state", state, STEP);
    check("step_stalled_pc", pc, RV + 32'h4);
    stall = 0;
    tick();
    check("step2_pc", pc, RV + 32'h8);
    check("step2_state", state, HALT);
    step_btn = 0; ticks(10);

    // Reset while in STEP
    step_btn = 1; stall = 1;
    for (int i = 0; i < 20 && state != STEP; i++) tick();
    check("step_reached", state, STEP);
    rst_n = 0; tick();
    rst_n = 1; stall = 0; step_btn = 0;
    check("rst_step_pc", pc, RV);
    check("rst_step_state", state, HALT);

    // Sequential wrap, then stall holds everything
    run_mode = 1;
    ticks(20);
    check("wrap_pc", pc, RV + 32'hC);
    check("wrap_fault", fault, 1'b0);
    stall = 1;
    ticks(3);
    check("stall_pc", pc, RV + 32'hC);
`ifdef PC_RETIRE_CNT_EN
    check("stall_retired", retired_count, 32'd19);
`endif
    stall = 0;

    // Randomized phase
    fault_age = 0;
    for (int n = 0; n < 3000; n++) begin
      fault_age = (m_state == FAULT) ? fault_age + 1 : 0;
      rst_n = !(($urandom_range(99) == 0) || fault_age > 4);
      if ($urandom_range(15) == 0) run_mode = !run_mode;
      if ($urandom_range(9) == 0)  step_btn = !step_btn;
      stall        = ($urandom_range(4) == 0);
      jalr         = ($urandom_range(9) == 0);
      jump         = ($urandom_range(9) == 0);
      branch_taken = ($urandom_range(6) == 0);
      imm          = 32'($signed($urandom_range(16)) - 8) * 4;
      if ($urandom_range(7) == 0) imm = imm + 32'd2;
      rs1_data     = RV - 32'd8 + 32'($urandom_range(80));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
